pipelined_decode_ctrl: RTL and testbench

Registered instruction-decode control stage for the MIPS-subset CPU. It decodes opcode/funct into datapath control and latches the result into the ID/EX pipeline register with one cycle of latency. It also detects load-use hazards against the instruction in EX, stalls the fetch side via a valid/ready handshake, and inserts bubbles on stall or branch flush. It sits between the IF/ID register and the execute stage.

---
 rtl/pipelined_decode_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_pipelined_decode_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_decode_ctrl.sv
// ---------------------------------------------------------------------------
// pipelined_decode_ctrl
//
// Registered instruction-decode control stage for a MIPS-subset CPU.
// Decodes opcode/funct into datapath controls and latches them into the
// ID/EX pipeline register (one cycle of latency). It also detects load-use
// hazards against the instruction already in EX, back-pressures the fetch
// side through id_ready, and inserts bubbles on a stall or a branch flush.
//
// Handshake: an ID instruction is transferred on a rising edge when
// id_valid & id_ready are both high. id_ready is combinational and may drop
// for one cycle on a load-use hazard. While id_ready is low the ID side must
// hold its instruction stable. flush forces id_ready high: the instruction is
// consumed and dropped.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   id_valid        ID stage holds a valid instruction
//   id_ready        stage accepts the ID instruction this cycle
//   opcode, fun     instruction[31:26], instruction[5:0]
//   rs, rt, rd      register specifiers of the ID instruction
//   flush           branch taken: discard the ID instruction
//   ex_valid        EX register holds a real instruction
//   writereg .. branch   registered datapath controls for EX
//   ex_dest         resolved destination register (0 when no write)
//   illegal         EX holds an undecodable instruction
//   illegal_seen    sticky flag, set when an illegal instruction is loaded
//   stall_cnt       saturating count of stall cycles
// ---------------------------------------------------------------------------
module pipelined_decode_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUC_W     = 4,
  parameter int HAZARD_EN  = 1,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [5:0]            opcode,
  input  logic [5:0]            fun,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  writereg,
  output logic                  memory2reg,
  output logic                  WMEM,
  output logic [ALUC_W-1:0]     ALUcontrol,
  output logic                  ALUImm,
  output logic                  regrt,
  output logic                  branch,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  illegal,
  output logic                  illegal_seen,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Opcodes and R-type function codes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes, zero-extended to the configured width
  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(4'b0000);
  localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(4'b0001);
  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(4'b0010);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(4'b0110);
  localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(4'b0111);

  // -------------------------------------------------------------------------
  // Combinational decode of the ID instruction
  // -------------------------------------------------------------------------
  logic                  w_writereg;
  logic                  w_memory2reg;
  logic                  w_wmem;
  logic [ALUC_W-1:0]     w_aluc;
  logic                  w_aluimm;
  logic                  w_regrt;
  logic                  w_branch;
  logic                  w_illegal;
  logic                  w_uses_rt;
  logic [REG_ADDR_W-1:0] w_dest;

  always_comb begin
    w_writereg   = 1'b0;
    w_memory2reg = 1'b0;
    w_wmem       = 1'b0;
    w_aluc       = '0;
    w_aluimm     = 1'b0;
    w_regrt      = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    w_uses_rt    = 1'b0;

    unique case (opcode)
      OP_RTYPE: begin
        w_uses_rt = 1'b1;
        unique case (fun)
          FN_ADD: begin w_writereg = 1'b1; w_aluc = ALU_ADD; end
          FN_SUB: begin w_writereg = 1'b1; w_aluc = ALU_SUB; end
          FN_AND: begin w_writereg = 1'b1; w_aluc = ALU_AND; end
          FN_OR:  begin w_writereg = 1'b1; w_aluc = ALU_OR;  end
          FN_SLT: begin w_writereg = 1'b1; w_aluc = ALU_SLT; end
          default: begin
            w_illegal = 1'b1;
            w_uses_rt = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        w_writereg   = 1'b1;
        w_memory2reg = 1'b1;
        w_aluc       = ALU_ADD;
        w_aluimm     = 1'b1;
        w_regrt      = 1'b1;
      end
      OP_SW: begin
        w_wmem    = 1'b1;
        w_aluc    = ALU_ADD;
        w_aluimm  = 1'b1;
        w_regrt   = 1'b1;
        w_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        w_writereg = 1'b1;
        w_aluc     = ALU_ADD;
        w_aluimm   = 1'b1;
        w_regrt    = 1'b1;
      end
      OP_BEQ: begin
        w_aluc    = ALU_SUB;
        w_branch  = 1'b1;
        w_uses_rt = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Destination is only meaningful for writing instructions; zeroing it
  // otherwise keeps the hazard compare from matching stale fields.
  assign w_dest = !w_writereg ? '0 : (w_regrt ? rt : rd);

  // -------------------------------------------------------------------------
  // EX pipeline register
  // -------------------------------------------------------------------------
  logic                  r_ex_valid;
  logic                  r_writereg;
  logic                  r_memory2reg;
  logic                  r_wmem;
  logic [ALUC_W-1:0]     r_aluc;
  logic                  r_aluimm;
  logic                  r_regrt;
  logic                  r_branch;
  logic [REG_ADDR_W-1:0] r_ex_dest;
  logic                  r_illegal;
  logic                  r_illegal_seen;
  logic [CNT_W-1:0]      r_stall_cnt;

  // -------------------------------------------------------------------------
  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. memory2reg implies a valid load, so ex_dest is its rt. Register 0
  // is hardwired and never creates a dependency.
  // -------------------------------------------------------------------------
  logic w_src_match;
  logic w_stall;

  assign w_src_match = (r_ex_dest == rs) || (w_uses_rt && (r_ex_dest == rt));

  assign w_stall = (HAZARD_EN != 0) && id_valid && r_ex_valid &&
                   r_memory2reg && (r_ex_dest != '0) && !w_illegal &&
                   w_src_match;

  assign id_ready = !w_stall || flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_writereg     <= 1'b0;
      r_memory2reg   <= 1'b0;
      r_wmem         <= 1'b0;
      r_aluc         <= '0;
      r_aluimm       <= 1'b0;
      r_regrt        <= 1'b0;
      r_branch       <= 1'b0;
      r_ex_dest      <= '0;
      r_illegal      <= 1'b0;
      r_illegal_seen <= 1'b0;
      r_stall_cnt    <= '0;
    end else if (!flush && !w_stall && id_valid) begin
      // Accepted instruction enters EX
      r_ex_valid     <= 1'b1;
      r_writereg     <= w_writereg;
      r_memory2reg   <= w_memory2reg;
      r_wmem         <= w_wmem;
      r_aluc         <= w_aluc;
      r_aluimm       <= w_aluimm;
      r_regrt        <= w_regrt;
      r_branch       <= w_branch;
      r_ex_dest      <= w_dest;
      r_illegal      <= w_illegal;
      if (w_illegal) begin
        r_illegal_seen <= 1'b1;
      end
    end else begin
      // Bubble: flush, stall or no instruction. Flush takes priority over a
      // stall, so a flushed stall does not count.
      r_ex_valid   <= 1'b0;
      r_writereg   <= 1'b0;
      r_memory2reg <= 1'b0;
      r_wmem       <= 1'b0;
      r_aluc       <= '0;
      r_aluimm     <= 1'b0;
      r_regrt      <= 1'b0;
      r_branch     <= 1'b0;
      r_ex_dest    <= '0;
      r_illegal    <= 1'b0;
      if (!flush && w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid     = r_ex_valid;
  assign writereg     = r_writereg;
  assign memory2reg   = r_memory2reg;
  assign WMEM         = r_wmem;
  assign ALUcontrol   = r_aluc;
  assign ALUImm       = r_aluimm;
  assign regrt        = r_regrt;
  assign branch       = r_branch;
  assign ex_dest      = r_ex_dest;
  assign illegal      = r_illegal;
  assign illegal_seen = r_illegal_seen;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipelined_decode_ctrl
//
// Drives directed and random instructions into pipelined_decode_ctrl. A
// reference model predicts id_ready each cycle and pushes the expected EX
// contents of every accepted instruction into exp_q; a monitor pops and
// compares whenever ex_valid is presented.
// ---------------------------------------------------------------------------
module tb_pipelined_decode_ctrl;

  localparam int REG_ADDR_W = 5;
  localparam int ALUC_W     = 4;
  localparam int HAZARD_EN  = 1;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       wr;
    logic       m2r;
    logic       wm;
    logic [3:0] alu;
    logic       imm;
    logic       rt_sel;
    logic       br;
    logic       ill;
    logic [4:0] dest;
  } ctrl_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic                  id_valid = 1'b0;
  logic                  id_ready;
  logic [5:0]            opcode = '0;
  logic [5:0]            fun = '0;
  logic [REG_ADDR_W-1:0] rs = '0;
  logic [REG_ADDR_W-1:0] rt = '0;
  logic [REG_ADDR_W-1:0] rd = '0;
  logic                  flush = 1'b0;
  logic                  ex_valid;
  logic                  writereg;
  logic                  memory2reg;
  logic                  WMEM;
  logic [ALUC_W-1:0]     ALUcontrol;
  logic                  ALUImm;
  logic                  regrt;
  logic                  branch;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  illegal;
  logic                  illegal_seen;
  logic [CNT_W-1:0]      stall_cnt;

  pipelined_decode_ctrl #(
    .REG_ADDR_W(REG_ADDR_W),
    .ALUC_W    (ALUC_W),
    .HAZARD_EN (HAZARD_EN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .opcode      (opcode),
    .fun         (fun),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .writereg    (writereg),
    .memory2reg  (memory2reg),
    .WMEM        (WMEM),
    .ALUcontrol  (ALUcontrol),
    .ALUImm      (ALUImm),
    .regrt       (regrt),
    .branch      (branch),
    .ex_dest     (ex_dest),
    .illegal     (illegal),
    .illegal_seen(illegal_seen),
    .stall_cnt   (stall_cnt)
  );

  ctrl_t dut_ctrl;
  assign dut_ctrl = '{wr: writereg, m2r: memory2reg, wm: WMEM, alu: ALUcontrol,
                      imm: ALUImm, rt_sel: regrt, br: branch, ill: illegal,
                      dest: ex_dest};

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic       m_ex_valid = 1'b0;
  logic       m_ex_m2r   = 1'b0;
  logic [4:0] m_ex_dest  = '0;
  int         m_cnt      = 0;
  logic       m_seen     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Decode table written directly from the instruction set description.
  function automatic ctrl_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] rt_i, input logic [4:0] rd_i);
    ctrl_t c;
    c = '0;
    case (op)
      6'b000000: begin
        c.wr = 1'b1;
        case (fn)
          6'b100000: c.alu = 4'b0010;
          6'b100010: c.alu = 4'b0110;
          6'b100100: c.alu = 4'b0000;
          6'b100101: c.alu = 4'b0001;
          6'b101010: c.alu = 4'b0111;
          default: begin c = '0; c.ill = 1'b1; end
        endcase
      end
      6'b100011: begin c.wr = 1; c.m2r = 1; c.alu = 4'b0010; c.imm = 1; c.rt_sel = 1; end
      6'b101011: begin c.wm = 1; c.alu = 4'b0010; c.imm = 1; c.rt_sel = 1; end
      6'b001000: begin c.wr = 1; c.alu = 4'b0010; c.imm = 1; c.rt_sel = 1; end
      6'b000100: begin c.alu = 4'b0110; c.br = 1; end
      default:   c.ill = 1'b1;
    endcase
    c.dest = c.wr ? (c.rt_sel ? rt_i : rd_i) : 5'd0;
    return c;
  endfunction

  function automatic logic ref_reads_rt(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b101011) || (op == 6'b000100);
  endfunction

  // Called mid-cycle with the ID inputs stable: predicts id_ready and the EX
  // contents after the next rising edge.
  task automatic model_step();
    ctrl_t c;
    logic  stall;
    c = ref_decode(opcode, fun, rt, rd);
    stall = (HAZARD_EN != 0) && id_valid && m_ex_valid && m_ex_m2r &&
            (m_ex_dest != 0) && !c.ill &&
            ((m_ex_dest == rs) || (ref_reads_rt(opcode) && (m_ex_dest == rt)));
    check("id_ready", {31'd0, id_ready}, {31'd0, (!stall || flush)});
    if (!flush && !stall && id_valid) begin
      m_ex_valid = 1'b1;
      m_ex_m2r   = c.m2r;
      m_ex_dest  = c.dest;
      exp_q.push_back(c);
      if (c.ill) m_seen = 1'b1;
    end else begin
      m_ex_valid = 1'b0;
      m_ex_m2r   = 1'b0;
      m_ex_dest  = '0;
      if (!flush && stall && (m_cnt < CNT_MAX)) m_cnt++;
    end
  endtask

  task automatic model_clear();
    m_ex_valid = 1'b0;
    m_ex_m2r   = 1'b0;
    m_ex_dest  = '0;
    m_cnt      = 0;
    m_seen     = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic fl);
    id_valid = v; opcode = op; fun = fn; rs = s; rt = t; rd = d; flush = fl;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    check({tag, "_ctrl"}, {16'd0, dut_ctrl}, 32'd0);
    check({tag, "_stall_cnt"}, {24'd0, stall_cnt}, 32'd0);
    check({tag, "_illegal_seen"}, {31'd0, illegal_seen}, 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      check("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_valid});
      if (ex_valid) begin
        if (exp_q.size() == 0) begin
          check("ex_unexpected", 32'd1, 32'd0);
        end else begin
          check("ex_ctrl", {16'd0, dut_ctrl}, {16'd0, exp_q.pop_front()});
        end
      end else begin
        check("bubble_ctrl", {16'd0, dut_ctrl}, 32'd0);
      end
      check("stall_cnt", {24'd0, stall_cnt}, m_cnt);
      check("illegal_seen", {31'd0, illegal_seen}, {31'd0, m_seen});
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [5:0] OPS [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b100011,
                                      6'b100011, 6'b101011, 6'b001000, 6'b000100,
                                      6'b111111, 6'b000010};
  localparam logic [5:0] FNS [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                      6'b101010, 6'b000000};

  initial begin
    logic [5:0] op_tab [10];
    logic [5:0] fn_tab [6];
    op_tab = OPS;
    fn_tab = FNS;

    // Asynchronous reset: outputs clear before any clock edge
    #1 rst = 1'b1;
    #3 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // add r3,r1,r2
    cycle(1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 0);
    cycle(0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0);

    // lw r5 then add using r5: one stall, then the add
    cycle(1, 6'b100011, 6'b000000, 5'd1, 5'd5, 5'd0, 0);
    cycle(1, 6'b000000, 6'b100000, 5'd5, 5'd2, 5'd7, 0);
    cycle(1, 6'b000000, 6'b100000, 5'd5, 5'd2, 5'd7, 0);
    cycle(0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0);

    // lw to r0 then reader of r0: no stall
    cycle(1, 6'b100011, 6'b000000, 5'd1, 5'd0, 5'd0, 0);
    cycle(1, 6'b000000, 6'b100010, 5'd0, 5'd0, 5'd4, 0);

    // Load-use stall together with flush: dropped, not counted
    cycle(1, 6'b100011, 6'b000000, 5'd2, 5'd6, 5'd0, 0);
    cycle(1, 6'b101011, 6'b000000, 5'd1, 5'd6, 5'd0, 1);
    cycle(0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0);

    // Illegal opcode, then legal instructions: sticky flag stays
    cycle(1, 6'b111111, 6'b000000, 5'd1, 5'd2, 5'd3, 0);
    cycle(1, 6'b001000, 6'b000000, 5'd1, 5'd9, 5'd0, 0);
    cycle(1, 6'b000100, 6'b000000, 5'd1, 5'd2, 5'd0, 0);
    cycle(1, 6'b000000, 6'b101010, 5'd1, 5'd2, 5'd8, 0);
    cycle(1, 6'b000000, 6'b100101, 5'd1, 5'd2, 5'd8, 0);
    cycle(1, 6'b000000, 6'b100100, 5'd1, 5'd2, 5'd8, 0);
    cycle(1, 6'b000000, 6'b111000, 5'd1, 5'd2, 5'd8, 0);

    // Random mix with a small register range so hazards are frequent
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 7) != 0),
            op_tab[$urandom_range(0, 9)],
            fn_tab[$urandom_range(0, 5)],
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
    end

    // Saturation: back-to-back dependent loads stall every other cycle
    for (int i = 0; i < 620; i++) begin
      cycle(1, 6'b100011, 6'b000000, 5'd5, 5'd5, 5'd0, 0);
    end
    check("stall_cnt_sat", {24'd0, stall_cnt}, CNT_MAX);

    // Reset asserted in the middle of a stall
    cycle(0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0);
    cycle(1, 6'b100011, 6'b000000, 5'd1, 5'd5, 5'd0, 0);
    id_valid = 1; opcode = 6'b000000; fun = 6'b100000; rs = 5'd5; rt = 5'd1; rd = 5'd2; flush = 0;
    @(negedge clk);
    model_step();
    #1 rst = 1'b1;
    #1 check_all_zero("midstall_reset");
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 model_step();
    @(posedge clk);
    #1;
    cycle(0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0);
    cycle(0, 6'b000000, 6'b000000, 5'd0, 5'd0, 5'd0, 0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
